// File: rtl/mips_dmem_arbiter.sv
// Data-RAM port arbiter between the MIPS CPU and a debug requester; debug steals one cycle.
// Define DMEM_ARB_DBG_WRITE_EN to let debug writes reach memory (otherwise debug is read-only).
module mips_dmem_arbiter #(
    parameter int MAX_WAIT = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_cpu_address,
    input  logic        i_cpu_read,
    input  logic        i_cpu_write,
    input  logic [31:0] i_cpu_writedata,
    output logic [31:0] o_cpu_readdata,
    output logic        o_cpu_stall,
    input  logic        i_dbg_valid,
    input  logic [31:0] i_dbg_address,
    input  logic        i_dbg_read,
    input  logic        i_dbg_write,
    input  logic [31:0] i_dbg_writedata,
    output logic        o_dbg_ack,
    output logic [31:0] o_dbg_readdata,
    output logic [31:0] o_mem_address,
    output logic        o_mem_read,
    output logic        o_mem_write,
    output logic [31:0] o_mem_writedata,
    input  logic [31:0] i_mem_readdata
);

    localparam int WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DBG  = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t        r_state;
    logic [WW-1:0] r_wait_cnt;
    logic          r_cpu_stall;
    logic          r_dbg_ack;
    logic [31:0]   r_dbg_readdata;

    logic w_cpu_busy;
    logic w_grant;
    logic w_dbg_mem_write;

    assign w_cpu_busy = i_cpu_read | i_cpu_write;
    assign w_grant    = i_dbg_valid & (~w_cpu_busy | (r_wait_cnt == WAIT_MAX));

`ifdef DMEM_ARB_DBG_WRITE_EN
    assign w_dbg_mem_write = i_dbg_write;
`else
    logic w_unused_dbg_write;
    assign w_unused_dbg_write = i_dbg_write;
    assign w_dbg_mem_write    = 1'b0;
`endif

    // r_cpu_stall is high exactly while in DBG, so it doubles as the port-ownership select
    always_comb begin
        o_mem_address   = i_cpu_address;
        o_mem_read      = i_cpu_read;
        o_mem_write     = i_cpu_write;
        o_mem_writedata = i_cpu_writedata;
        if (r_cpu_stall) begin
            o_mem_address   = i_dbg_address;
            o_mem_write     = w_dbg_mem_write;
            o_mem_read      = i_dbg_read & ~w_dbg_mem_write;
            o_mem_writedata = i_dbg_writedata;
        end
    end

    assign o_cpu_readdata = i_mem_readdata;
    assign o_cpu_stall    = r_cpu_stall;
    assign o_dbg_ack      = r_dbg_ack;
    assign o_dbg_readdata = r_dbg_readdata;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state        <= ST_IDLE;
            r_wait_cnt     <= '0;
            r_cpu_stall    <= 1'b0;
            r_dbg_ack      <= 1'b0;
            r_dbg_readdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_dbg_ack <= 1'b0;
                    if (!i_dbg_valid) begin
                        r_wait_cnt <= '0;
                    end else if (w_grant) begin
                        r_state     <= ST_DBG;
                        r_cpu_stall <= 1'b1;
                        r_wait_cnt  <= '0;
                    end else if (r_wait_cnt != WAIT_MAX) begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                ST_DBG: begin
                    // captured before the write edge, so read+write returns the old word
                    r_dbg_readdata <= i_mem_readdata;
                    r_cpu_stall    <= 1'b0;
                    r_dbg_ack      <= 1'b1;
                    r_state        <= ST_ACK;
                end
                ST_ACK: begin
                    r_dbg_ack <= 1'b0;
                    r_state   <= ST_IDLE;
                    if (!i_dbg_valid) r_wait_cnt <= '0;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_cpu_stall <= 1'b0;
                    r_dbg_ack   <= 1'b0;
                    r_wait_cnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_dmem_arbiter.sv
// Directed bench for mips_dmem_arbiter with a small combinational-read data RAM model.
module tb_mips_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cpu_address, cpu_writedata, cpu_readdata;
    logic        cpu_read, cpu_write, cpu_stall;
    logic        dbg_valid, dbg_read, dbg_write, dbg_ack;
    logic [31:0] dbg_address, dbg_writedata, dbg_readdata;
    logic [31:0] mem_address, mem_writedata, mem_readdata;
    logic        mem_read, mem_write;

    logic [31:0] ram [0:63];
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign mem_readdata = ram[mem_address[7:2]];
    always @(posedge clk) if (mem_write) ram[mem_address[7:2]] <= mem_writedata;

    mips_dmem_arbiter #(.MAX_WAIT(4)) dut (
        .i_clk(clk), .i_reset(reset),
        .i_cpu_address(cpu_address), .i_cpu_read(cpu_read), .i_cpu_write(cpu_write),
        .i_cpu_writedata(cpu_writedata), .o_cpu_readdata(cpu_readdata), .o_cpu_stall(cpu_stall),
        .i_dbg_valid(dbg_valid), .i_dbg_address(dbg_address), .i_dbg_read(dbg_read),
        .i_dbg_write(dbg_write), .i_dbg_writedata(dbg_writedata),
        .o_dbg_ack(dbg_ack), .o_dbg_readdata(dbg_readdata),
        .o_mem_address(mem_address), .o_mem_read(mem_read), .o_mem_write(mem_write),
        .o_mem_writedata(mem_writedata), .i_mem_readdata(mem_readdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

`ifdef DMEM_ARB_DBG_WRITE_EN
    localparam logic        EXP_DBG_WR = 1'b1;
    localparam logic [31:0] EXP_WORD16 = 32'hBBBBFFFF;
`else
    localparam logic        EXP_DBG_WR = 1'b0;
    localparam logic [31:0] EXP_WORD16 = 32'hA5A50004;
`endif

    initial begin
        for (int i = 0; i < 64; i++) ram[i] = 32'h1000_0000 + i;
        ram[2] = 32'h0000_0808;
        ram[4] = 32'hA5A5_0004;
        ram[5] = 32'hF896_3EF0;
        reset = 1'b1;
        cpu_address = 0; cpu_read = 0; cpu_write = 0; cpu_writedata = 0;
        dbg_valid = 0; dbg_address = 0; dbg_read = 0; dbg_write = 0; dbg_writedata = 0;

        // reset state: outputs low, memory port follows CPU
        #2;
        cpu_address = 32'h30; cpu_write = 1'b1; cpu_writedata = 32'h1234;
        #1;
        chk("rst_stall", {31'd0, cpu_stall}, 32'd0);
        chk("rst_ack", {31'd0, dbg_ack}, 32'd0);
        chk("rst_rdata", dbg_readdata, 32'd0);
        chk("rst_mem_wr", {31'd0, mem_write}, 32'd1);
        chk("rst_mem_addr", mem_address, 32'h30);
        cpu_write = 1'b0;
        tick();
        reset = 1'b0;
        tick();

        // CPU-only read of address 16
        cpu_read = 1'b1; cpu_address = 32'd16;
        #1;
        chk("cpu_addr", mem_address, 32'd16);
        chk("cpu_rd", {31'd0, mem_read}, 32'd1);
        chk("cpu_rdata", cpu_readdata, 32'hA5A50004);
        tick();
        chk("cpu_stall", {31'd0, cpu_stall}, 32'd0);
        cpu_read = 1'b0;

        // debug read with CPU idle
        dbg_valid = 1'b1; dbg_read = 1'b1; dbg_address = 32'd20;
        tick();
        chk("dr_stall", {31'd0, cpu_stall}, 32'd1);
        chk("dr_mem_addr", mem_address, 32'd20);
        chk("dr_mem_rd", {31'd0, mem_read}, 32'd1);
        chk("dr_ack_early", {31'd0, dbg_ack}, 32'd0);
        tick();
        chk("dr_ack", {31'd0, dbg_ack}, 32'd1);
        chk("dr_rdata", dbg_readdata, 32'hF8963EF0);
        chk("dr_stall_off", {31'd0, cpu_stall}, 32'd0);
        dbg_valid = 1'b0;
        tick();
        chk("dr_ack_pulse", {31'd0, dbg_ack}, 32'd0);

        // starvation: CPU reads address 8 every cycle
        cpu_read = 1'b1; cpu_address = 32'd8;
        dbg_valid = 1'b1; dbg_read = 1'b1; dbg_address = 32'd12;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("sv_block%0d", i), {31'd0, cpu_stall}, 32'd0);
        end
        tick();
        chk("sv_stall", {31'd0, cpu_stall}, 32'd1);
        chk("sv_mem_addr", mem_address, 32'd12);
        tick();
        chk("sv_ack", {31'd0, dbg_ack}, 32'd1);
        chk("sv_rdata", dbg_readdata, 32'h10000003);
        chk("sv_cpu_addr", mem_address, 32'd8);
        chk("sv_cpu_rdata", cpu_readdata, 32'h00000808);
        dbg_valid = 1'b0; cpu_read = 1'b0;
        tick();

        // debug write of 0xBBBBFFFF to 16
        dbg_valid = 1'b1; dbg_read = 1'b0; dbg_write = 1'b1;
        dbg_address = 32'd16; dbg_writedata = 32'hBBBBFFFF;
        tick();
        chk("dw_mem_wr", {31'd0, mem_write}, {31'd0, EXP_DBG_WR});
        chk("dw_mem_rd", {31'd0, mem_read}, 32'd0);
        chk("dw_wdata", mem_writedata, 32'hBBBBFFFF);
        tick();
        chk("dw_ack", {31'd0, dbg_ack}, 32'd1);
        chk("dw_rdata_old", dbg_readdata, 32'hA5A50004);
        dbg_valid = 1'b0; dbg_write = 1'b0;
        cpu_read = 1'b1; cpu_address = 32'd16;
        #1;
        chk("dw_cpu_rdata", cpu_readdata, EXP_WORD16);
        cpu_read = 1'b0;
        tick();

        // reset asserted during DBG
        dbg_valid = 1'b1; dbg_read = 1'b1; dbg_address = 32'd20;
        tick();
        chk("rs_in_dbg", {31'd0, cpu_stall}, 32'd1);
        reset = 1'b1; cpu_write = 1'b1; cpu_address = 32'h34;
        #1;
        chk("rs_stall", {31'd0, cpu_stall}, 32'd0);
        chk("rs_ack", {31'd0, dbg_ack}, 32'd0);
        chk("rs_mem_wr", {31'd0, mem_write}, 32'd1);
        chk("rs_mem_addr", mem_address, 32'h34);
        cpu_write = 1'b0; dbg_valid = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        chk("rs_no_ack1", {31'd0, dbg_ack}, 32'd0);
        tick();
        chk("rs_no_ack2", {31'd0, dbg_ack}, 32'd0);

        // back-to-back: dbg_valid held through the first ack
        dbg_valid = 1'b1; dbg_read = 1'b1; dbg_address = 32'd20;
        tick();
        chk("bb_stall1", {31'd0, cpu_stall}, 32'd1);
        tick();
        chk("bb_ack1", {31'd0, dbg_ack}, 32'd1);
        tick();
        chk("bb_gap_ack", {31'd0, dbg_ack}, 32'd0);
        chk("bb_gap_stall", {31'd0, cpu_stall}, 32'd0);
        tick();
        chk("bb_stall2", {31'd0, cpu_stall}, 32'd1);
        chk("bb_gap_ack2", {31'd0, dbg_ack}, 32'd0);
        tick();
        chk("bb_ack2", {31'd0, dbg_ack}, 32'd1);
        chk("bb_rdata2", dbg_readdata, 32'hF8963EF0);
        dbg_valid = 1'b0;
        tick();
        chk("bb_end_ack", {31'd0, dbg_ack}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mips_dmem_arbiter.md
# mips_dmem_arbiter

Shares the single data-RAM port of the Harvard MIPS system between the CPU data interface and a debug/testbench requester. The CPU keeps the port by default; debug requests are granted when the CPU is idle, or forcibly after a bounded wait by stalling the CPU for one cycle. `cpu_stall` feeds the CPU `clk_enable` (inverted) so a stalled CPU re-presents its access unchanged.

## Interface
- `MAX_WAIT`, default 4: cycles a pending debug request may be blocked by CPU traffic before it is force-granted (≥1).
- `clk` in 1: clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high.
- `cpu_address` in 32: CPU byte address.
- `cpu_read` / `cpu_write` in 1: CPU access strobes.
- `cpu_writedata` in 32: CPU store data.
- `cpu_readdata` out 32: `mem_readdata`, passed through combinationally.
- `cpu_stall` out 1: high while the port is owned by debug.
- `dbg_valid` in 1: debug request; address/data/strobes held stable until `dbg_ack`.
- `dbg_address` in 32, `dbg_read` in 1, `dbg_write` in 1, `dbg_writedata` in 32.
- `dbg_ack` out 1: one-cycle completion pulse.
- `dbg_readdata` out 32: registered read result, valid with `dbg_ack`.
- `mem_address` out 32, `mem_read` out 1, `mem_write` out 1, `mem_writedata` out 32: to data RAM (combinational read, write at rising edge).
- `mem_readdata` in 32: from data RAM.

## Operation
- States: IDLE, DBG, ACK.
- IDLE: memory port driven from `cpu_*`; `cpu_stall`=0.
- `cpu_busy` = `cpu_read | cpu_write`. Grant condition in IDLE: `dbg_valid & (~cpu_busy | wait_cnt == MAX_WAIT)` → DBG at next edge.
- `wait_cnt`: in IDLE, increments (saturating at MAX_WAIT) each edge with `dbg_valid & cpu_busy` and no grant; cleared on entering DBG and whenever `dbg_valid`=0.
- DBG (exactly one cycle): memory port driven from `dbg_*`; `cpu_stall`=1; `mem_read` = `dbg_read & ~mem_write`; if both `dbg_read` and `dbg_write`, write wins and `dbg_readdata` captures the pre-write word. At the edge: `dbg_readdata` <= `mem_readdata`, → ACK.
- ACK (one cycle): `dbg_ack`=1; port returned to CPU, `cpu_stall`=0; no grant evaluated. → IDLE. `dbg_valid` still high in the following IDLE cycle counts as a new request.
- `dbg_valid` with neither strobe: still sequenced through DBG/ACK; no memory strobe.
- Reset (any state, asynchronously): state IDLE, `wait_cnt`=0, `dbg_ack`=0, `dbg_readdata`=0, `cpu_stall`=0; memory port follows CPU immediately. An in-flight debug access is dropped without ack.

## Timing
- CPU path: zero latency, purely combinational when in IDLE/ACK.
- Debug latency, CPU idle: `dbg_valid` sampled at edge N → DBG in cycle N+1 → `dbg_ack`/data in cycle N+2.
- Debug latency, CPU saturated: at most MAX_WAIT+2 cycles from request to ack.
- CPU loses exactly one cycle per debug access.
- Reset values: all outputs 0 except pass-throughs (`mem_*`, `cpu_readdata`) which follow CPU inputs.

## Configuration
- `DMEM_ARB_DBG_WRITE_EN` defined: debug writes reach memory as above.
- Not defined: `dbg_write` ignored; `mem_write` is 0 in DBG; `dbg_read`+`dbg_write` behaves as plain read; write-only requests still complete with `dbg_ack` and no memory change.

## Test plan
- CPU only: `cpu_read`, `cpu_address`=16 → `mem_address`=16, `mem_read`=1 same cycle, `cpu_stall` never 1, `cpu_readdata`=RAM word.
- Debug read, CPU idle: `dbg_valid`, `dbg_read`, address 20, RAM holds 0xF8963EF0 → DBG next cycle, `dbg_ack` one cycle later with `dbg_readdata`=0xF8963EF0; `cpu_stall` high exactly one cycle.
- Starvation, MAX_WAIT=4: CPU reads address 8 every cycle, `dbg_valid` raised → grant after 4 blocked edges, ack at 6 cycles; CPU address 8 unchanged after stall.
- Debug write (macro defined): write 0xBBBBFFFF to 16, then CPU reads 16 → 0xBBBBFFFF. Macro undefined: CPU reads original value; `dbg_ack` still pulses.
- Reset asserted mid-DBG → `cpu_stall`=0, `dbg_ack`=0 immediately, `mem_write` follows `cpu_write`; no ack after release.
- Back-to-back: `dbg_valid` held through ack → second access granted in IDLE after ACK; two acks separated by ≥2 cycles.
